// File: rtl/perceptron_pkg.sv
// Shared widths, label encodings and helpers for the perceptron training and
// inference datapaths.
package perceptron_pkg;

  localparam int XW     = 7;
  localparam int WW     = 14;
  localparam int WSHIFT = 4;
  localparam int CNTW   = 16;
  localparam int SW     = XW + WW + WSHIFT + 1;
  localparam int PW     = XW + WW;

  localparam logic [1:0] LBL_POS  = 2'b01;
  localparam logic [1:0] LBL_NEG  = 2'b11;
  localparam logic [1:0] LBL_NONE = 2'b00;

  // Zero counts as positive, matching the training comparator.
  function automatic logic [1:0] sign_to_label(input logic neg);
    return neg ? LBL_NEG : LBL_POS;
  endfunction

  // The reserved code 2'b10 is folded into "unlabeled".
  function automatic logic [1:0] norm_label(input logic [1:0] lbl);
    return (lbl == LBL_POS || lbl == LBL_NEG) ? lbl : LBL_NONE;
  endfunction

endpackage

// File: rtl/perceptron_dot2.sv
// Registered first pipeline stage: both weight products plus a snapshot of
// bias, label and valid, so a sample never mixes old and new weights.
module perceptron_dot2
  import perceptron_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv_i,
  input  logic                 valid_i,
  input  logic signed [XW-1:0] x1_i,
  input  logic signed [XW-1:0] x2_i,
  input  logic signed [WW-1:0] w1_i,
  input  logic signed [WW-1:0] w2_i,
  input  logic signed [WW-1:0] bias_i,
  input  logic [1:0]           t_i,
  output logic                 valid_o,
  output logic signed [PW-1:0] p1_o,
  output logic signed [PW-1:0] p2_o,
  output logic signed [WW-1:0] bias_o,
  output logic [1:0]           t_o
);

  logic                 valid_q;
  logic signed [PW-1:0] p1_q, p2_q, p1_d, p2_d;
  logic signed [WW-1:0] bias_q;
  logic [1:0]           t_q;

  assign p1_d = PW'(x1_i) * PW'(w1_i);
  assign p2_d = PW'(x2_i) * PW'(w2_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      bias_q  <= '0;
      t_q     <= LBL_NONE;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        p1_q   <= p1_d;
        p2_q   <= p2_d;
        bias_q <= bias_i;
        t_q    <= t_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign p1_o    = p1_q;
  assign p2_o    = p2_q;
  assign bias_o  = bias_q;
  assign t_o     = t_q;

endmodule

// File: rtl/perceptron_classifier.sv
// Two-stage pipelined perceptron inference with valid/ready flow control and
// saturating accuracy counters.
module perceptron_classifier
  import perceptron_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_weights,
  input  logic signed [WW-1:0] W1,
  input  logic signed [WW-1:0] W2,
  input  logic signed [WW-1:0] Bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [XW-1:0] X1,
  input  logic signed [XW-1:0] X2,
  input  logic [1:0]           t,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [SW-1:0] y_sum,
  output logic [1:0]           y_class,
  output logic                 match,
  input  logic                 clr_stats,
  output logic [CNTW-1:0]      total_cnt,
  output logic [CNTW-1:0]      err_cnt
);

  logic signed [WW-1:0] w1_q, w2_q, bias_q;
  logic                 adv1, adv2, accept, out_fire;
  logic                 s1_valid;
  logic signed [PW-1:0] s1_p1, s1_p2;
  logic signed [WW-1:0] s1_bias;
  logic [1:0]           s1_t;
  logic signed [SW-1:0] sum_d, y_sum_q;
  logic [1:0]           cls_d, y_class_q, lbl_q;
  logic                 match_d, match_q, out_valid_q;
  logic [CNTW-1:0]      total_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1_q   <= '0;
      w2_q   <= '0;
      bias_q <= '0;
    end else if (ld_weights) begin
      w1_q   <= W1;
      w2_q   <= W2;
      bias_q <= Bias;
    end
  end

  // Refusing input during a load keeps every accepted sample on one weight set.
  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !ld_weights;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  perceptron_dot2 u_dot2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (adv1),
    .valid_i (accept),
    .x1_i    (X1),
    .x2_i    (X2),
    .w1_i    (w1_q),
    .w2_i    (w2_q),
    .bias_i  (bias_q),
    .t_i     (norm_label(t)),
    .valid_o (s1_valid),
    .p1_o    (s1_p1),
    .p2_o    (s1_p2),
    .bias_o  (s1_bias),
    .t_o     (s1_t)
  );

  assign sum_d   = ((SW'(s1_p1) + SW'(s1_p2)) <<< WSHIFT) + SW'(s1_bias);
  assign cls_d   = sign_to_label(sum_d[SW-1]);
  assign match_d = (s1_t != LBL_NONE) && (cls_d == s1_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_sum_q     <= '0;
      y_class_q   <= LBL_POS;
      match_q     <= 1'b0;
      lbl_q       <= LBL_NONE;
    end else if (adv2) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        y_sum_q   <= sum_d;
        y_class_q <= cls_d;
        match_q   <= match_d;
        lbl_q     <= s1_t;
      end
    end
  end

  // A clear on the same edge as a handshake drops that sample from the stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      err_q   <= '0;
    end else if (clr_stats) begin
      total_q <= '0;
      err_q   <= '0;
    end else if (out_fire && lbl_q != LBL_NONE) begin
      if (total_q != '1) total_q <= total_q + CNTW'(1);
      if (!match_q && err_q != '1) err_q <= err_q + CNTW'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign y_sum     = y_sum_q;
  assign y_class   = y_class_q;
  assign match     = match_q;
  assign total_cnt = total_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_perceptron_classifier.sv
// Self-checking bench for perceptron_classifier: directed scenarios followed by
// random traffic, scored against an arithmetic reference model.
module tb_perceptron_classifier;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ld_weights;
  logic signed [13:0] W1, W2, Bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [6:0]  X1, X2;
  logic [1:0]         t;
  logic               out_valid;
  logic               out_ready;
  logic signed [25:0] y_sum;
  logic [1:0]         y_class;
  logic               match;
  logic               clr_stats;
  logic [15:0]        total_cnt, err_cnt;

  perceptron_classifier dut (
    .clk(clk), .rst_n(rst_n), .ld_weights(ld_weights),
    .W1(W1), .W2(W2), .Bias(Bias),
    .in_valid(in_valid), .in_ready(in_ready),
    .X1(X1), .X2(X2), .t(t),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_sum(y_sum), .y_class(y_class), .match(match),
    .clr_stats(clr_stats), .total_cnt(total_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { longint x1; longint x2; logic [1:0] t; } sample_t;
  typedef struct { longint sum; logic [1:0] cls; logic m; logic lab; } exp_t;

  sample_t pend[$];
  exp_t    sb[$];
  longint  mW1, mW2, mB;
  longint  mTotal, mErr;
  int      compared = 0;
  int      mismatched = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The classifier's contract expressed as plain integer arithmetic.
  function automatic exp_t refModel(input sample_t s);
    exp_t e;
    e.sum = (s.x1 * mW1 + s.x2 * mW2) * 16 + mB;
    e.cls = (e.sum >= 0) ? 2'b01 : 2'b11;
    e.lab = (s.t == 2'b01) || (s.t == 2'b11);
    e.m   = e.lab && (e.cls == s.t);
    return e;
  endfunction

  task automatic pushSample(input longint x1, input longint x2, input logic [1:0] lbl);
    sample_t s;
    s.x1 = x1; s.x2 = x2; s.t = lbl;
    pend.push_back(s);
  endtask

  task automatic checkOutput(output exp_t e, output bit got);
    got = 1'b0;
    e = '{0, 2'b00, 1'b0, 1'b0};
    if (sb.size() == 0) begin
      check("spurious_out_valid", out_valid, 0);
    end else begin
      e = sb.pop_front();
      got = 1'b1;
      check("y_sum", y_sum, e.sum);
      check("y_class", y_class, e.cls);
      check("match", match, e.m);
    end
  endtask

  // One clock cycle: drive at the falling edge, judge handshakes just before
  // the rising edge, then compare counters at the next falling edge.
  task automatic applyStimulus(input bit ld, input bit clr, input bit rdy);
    bit      inFire, outFire, got;
    exp_t    e;
    sample_t s;
    ld_weights = ld;
    clr_stats  = clr;
    out_ready  = rdy;
    if (pend.size() > 0) begin
      s = pend[0];
      in_valid = 1'b1;
      X1 = 7'(s.x1);
      X2 = 7'(s.x2);
      t  = s.t;
    end else begin
      in_valid = 1'b0;
      X1 = '0; X2 = '0; t = 2'b00;
    end
    #2;
    check("in_ready", in_ready, (!ld && (sb.size() < 2 || rdy)));
    inFire  = in_valid && in_ready;
    outFire = out_valid && rdy;
    got = 1'b0;
    if (outFire) checkOutput(e, got);
    if (clr) begin
      mTotal = 0;
      mErr   = 0;
    end else if (got && e.lab) begin
      if (mTotal < 65535) mTotal++;
      if (!e.m && mErr < 65535) mErr++;
    end
    if (inFire) begin
      sb.push_back(refModel(s));
      void'(pend.pop_front());
    end
    if (ld) begin
      mW1 = W1; mW2 = W2; mB = Bias;
    end
    @(negedge clk);
    check("total_cnt", total_cnt, mTotal);
    check("err_cnt", err_cnt, mErr);
  endtask

  task automatic loadWeights(input longint w1, input longint w2, input longint b);
    W1 = 14'(w1); W2 = 14'(w2); Bias = 14'(b);
    applyStimulus(1'b1, 1'b0, 1'b1);
  endtask

  task automatic drain(input bit rndReady);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < 200) begin
      applyStimulus(1'b0, 1'b0, rndReady ? 1'($urandom_range(1)) : 1'b1);
      n++;
    end
    check("drain_outstanding", pend.size() + sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ld, clr, rdy;
    rst_n = 1'b0; ld_weights = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; X1 = '0; X2 = '0; t = 2'b00;
    W1 = '0; W2 = '0; Bias = '0;
    mW1 = 0; mW2 = 0; mB = 0; mTotal = 0; mErr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_total", total_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_y_class", y_class, 2'b01);
    check("rst_y_sum", y_sum, 0);
    check("rst_match", match, 0);
    @(negedge clk);

    // Positive labeled sample with two-cycle latency.
    loadWeights(12, 0, 0);
    pushSample(3, -5, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("pos_latency_valid", out_valid, 1);
    check("pos_sum", y_sum, 576);
    drain(1'b0);

    // Negative class against a positive label counts as an error.
    loadWeights(-24, 12, -192);
    pushSample(2, 1, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("neg_sum", y_sum, -768);
    check("neg_class", y_class, 2'b11);
    drain(1'b0);

    // Largest magnitude operands.
    loadWeights(-8192, -8192, 8191);
    pushSample(-64, -64, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("ext_sum", y_sum, 16785407);
    drain(1'b0);

    // All-zero weights give a zero sum, classified as +1.
    loadWeights(0, 0, 0);
    pushSample(17, -33, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("zero_class", y_class, 2'b01);
    drain(1'b0);

    // Backpressure: only two samples fit while the consumer stalls.
    loadWeights(5, -7, 100);
    pushSample(10, 3, 2'b01);
    pushSample(-20, 8, 2'b11);
    pushSample(63, -64, 2'b00);
    pushSample(-1, 1, 2'b10);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    check("bp_in_flight", sb.size(), 2);
    check("bp_in_ready", in_ready, 0);
    drain(1'b0);

    // Reload while stage 1 is occupied: that sample keeps the old weights.
    loadWeights(10, 10, 0);
    pushSample(1, 1, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0);
    W1 = -14'sd100; W2 = 14'sd3; Bias = -14'sd50;
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushSample(1, 1, 2'b01);
    drain(1'b0);

    // Clear coincident with a labeled handshake wins.
    pushSample(4, 4, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    check("clr_total", total_cnt, 0);
    check("clr_err", err_cnt, 0);

    // Random traffic with occasional reloads, clears and stalls.
    for (int i = 0; i < 200; i++) begin
      ld  = ($urandom_range(9) == 0);
      clr = ($urandom_range(24) == 0);
      rdy = ($urandom_range(3) != 0);
      if (ld) begin
        W1 = 14'($urandom); W2 = 14'($urandom); Bias = 14'($urandom);
      end
      if (pend.size() < 2 && $urandom_range(4) != 0)
        pushSample(longint'($urandom_range(127)) - 64, longint'($urandom_range(127)) - 64, 2'($urandom));
      applyStimulus(ld, clr, rdy);
    end
    drain(1'b1);

    // Reset in the middle of traffic discards in-flight samples.
    loadWeights(3, 3, 3);
    pushSample(5, 5, 2'b01);
    pushSample(6, 6, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_total", total_cnt, 0);
    sb.delete();
    pend.delete();
    mW1 = 0; mW2 = 0; mB = 0; mTotal = 0; mErr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    pushSample(-7, 9, 2'b01);
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/perceptron_classifier.md
# perceptron_classifier

Inference stage downstream of the perceptron training datapath. Captures the trained weight set (W1, W2, Bias) once training reports its end flag. Streams (X1, X2, optional label) samples through a two-stage pipelined dot product and emits the ±1 class of each sample. Keeps saturating total/error counters so the controller can read classification accuracy.

## Interface
- XW, 7: signed sample width (X1, X2).
- WW, 14: signed weight/bias width.
- WSHIFT, 4: left shift applied to W1/W2 products, aligning them with Bias scale.
- CNTW, 16: statistics counter width.
- SW, derived = XW+WW+WSHIFT+1 (26): signed sum width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_weights  in  1  capture W1/W2/Bias this cycle.
- W1, W2, Bias  in  WW each  signed trained weights from training datapath.
- in_valid  in  1  sample present.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- X1, X2  in  XW each  signed sample.
- t  in  2  label: 2'b01 = +1, 2'b11 = −1, 2'b00 = unlabeled.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- y_sum  out  SW  signed full-width sum.
- y_class  out  2  2'b01 (+1) or 2'b11 (−1).
- match  out  1  labeled and y_class == t; 0 for unlabeled samples.
- clr_stats  in  1  synchronous clear of counters.
- total_cnt, err_cnt  out  CNTW each  labeled results delivered / mismatched.

## Operation
- Weight registers load on ld_weights. in_ready = 0 in any cycle with ld_weights = 1.
- Sum = (X1·W1 + X2·W2)·2^WSHIFT + Bias. All operands are sign-extended to SW. No truncation or overflow is possible.
- Class is taken from the full-width sign: sum ≥ 0 → 2'b01, sum < 0 → 2'b11. Zero maps to +1, the same convention the training comparator uses.
- Stage 1 registers P1 = X1·W1, P2 = X2·W2, a Bias snapshot, t, and valid.
  - Every sample finishes with the weight set current at its acceptance.
  - A mid-flight ld_weights never mixes old and new weights.
- Stage 2 registers y_sum, y_class, match, and out_valid.
- Flow control:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 && !ld_weights.
  - Stages move only on their advance signal. Output holds stable while out_valid && !out_ready.
- Statistics update on output handshake with t ≠ 2'b00: total_cnt +1, and err_cnt +1 if !match. Both saturate at all-ones.
- clr_stats wins over a simultaneous handshake: counters go to 0 and that sample is not counted.
- Illegal label 2'b10 is treated as unlabeled.

## Timing
- Latency: accept at edge N → out_valid at edge N+2 when unstalled. Throughput is 1 sample/cycle.
- Pipeline holds 2 samples. With out_ready = 0, in_ready drops after the second accept.
- in_ready is combinational from out_valid, s1_valid, out_ready, and ld_weights. No combinational path runs from in_valid to any output.
- Reset values:
  - in_ready = 1 (when ld_weights = 0).
  - out_valid = 0, s1_valid = 0.
  - y_sum = 0, y_class = 2'b01, match = 0.
  - Weights = 0, counters = 0.
- Reset mid-operation discards in-flight samples immediately. No result is emitted for them.

## Structure
- perceptron_pkg holds:
  - Width constants XW, WW, WSHIFT, SW, CNTW.
  - Label constants LBL_POS = 2'b01, LBL_NEG = 2'b11, LBL_NONE = 2'b00.
  - A sign-to-label function shared with the training datapath.
- One sub-module, perceptron_dot2. It is the registered stage 1: two signed multipliers plus the Bias/label/valid snapshot, with an advance-enable input.
- Stage 2, flow control, and counters live in the top module.

## Test plan
- Reset: hold rst_n low, release → out_valid = 0, in_ready = 1, total_cnt = err_cnt = 0, y_class = 2'b01.
- Positive: load W1 = 12, W2 = 0, Bias = 0, then send X1 = 3, X2 = −5, t = 01. Expect y_sum = 576, y_class = 01, match = 1 two cycles after accept; total_cnt = 1, err_cnt = 0.
- Negative/error: load W1 = −24, W2 = 12, Bias = −192, then send X1 = 2, X2 = 1, t = 01. Expect y_sum = −768, y_class = 11, match = 0, err_cnt = 1.
- Extremes and zero:
  - X1 = X2 = −64, W1 = W2 = −8192, Bias = 8191 → y_sum = 16785407 with no overflow.
  - All-zero weights → y_sum = 0, y_class = 01.
- Backpressure: out_ready = 0 with 4 back-to-back samples. Expect exactly 2 accepted and in_ready = 0. Release out_ready → outputs arrive in order, none lost or duplicated, and the remaining 2 are then accepted.
- Mid-flight reload and clear:
  - ld_weights while s1 is full → the in-flight result uses the old weights, and in_ready = 0 that cycle.
  - clr_stats coincident with a labeled handshake → both counters = 0 the next cycle.
